// File: rtl/vga_pkg.sv
// Shared constants, pixel flag bundle and elaboration helpers for the VGA matrix renderer.
package vga_pkg;

  localparam int CNT_W = 11;

  localparam logic [11:0] COL_BLANK  = 12'h000;
  localparam logic [11:0] COL_BORDER = 12'hFFF;
  localparam logic [11:0] COL_BG     = 12'h002;

  typedef struct packed {
    logic valid;
    logic blank;
    logic in_grid;
    logic border;
  } pix_flags_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = int'(i) + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// pix_en-gated delay line: syncs travel DEPTH stages, per-pixel flags are held one stage.
module vga_sync_delay
  import vga_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       hsync_i,
  input  logic       vsync_i,
  input  pix_flags_t flags_i,
  output pix_flags_t flags_o,
  output logic       hsync_o,
  output logic       vsync_o
);

  logic [DEPTH-1:0] hs_q;
  logic [DEPTH-1:0] vs_q;
  pix_flags_t       flags_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_q    <= '0;
      vs_q    <= '0;
      flags_q <= '0;
    end else if (en) begin
      hs_q[0] <= hsync_i;
      vs_q[0] <= vsync_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        hs_q[i] <= hs_q[i-1];
        vs_q[i] <= vs_q[i-1];
      end
      flags_q <= flags_i;
    end
  end

  assign flags_o = flags_q;
  assign hsync_o = hs_q[DEPTH-1];
  assign vsync_o = vs_q[DEPTH-1];

endmodule

// File: rtl/vga_matrix_pixel_gen.sv
// Renders an N x N result matrix as bordered grayscale cells, reading a double-buffered RAM
// and owning the vblank-synchronised buffer swap with the matrix engine.
module vga_matrix_pixel_gen
  import vga_pkg::*;
#(
  parameter int N        = 4,
  parameter int DATA_W   = 8,
  parameter int CELL_PX  = 64,
  parameter int BORDER   = 2,
  parameter int ORIGIN_X = 64,
  parameter int ORIGIN_Y = 48,
  parameter int ADDR_W   = 1 + 2 * clog2(N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_en,
  input  logic [10:0]       h_count,
  input  logic [10:0]       v_count,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              hblank,
  input  logic              vblank,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              buf_sel,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              vga_hsync,
  output logic              vga_vsync
);

  localparam int LOG_N    = clog2(N);
  localparam int LOG_CELL = clog2(CELL_PX);

  localparam logic [CNT_W-1:0] ORG_X     = CNT_W'(ORIGIN_X);
  localparam logic [CNT_W-1:0] ORG_Y     = CNT_W'(ORIGIN_Y);
  localparam logic [CNT_W-1:0] GRID_PX   = CNT_W'(N * CELL_PX);
  localparam logic [CNT_W-1:0] CELL_MASK = CNT_W'(CELL_PX - 1);
  localparam logic [CNT_W-1:0] BORDER_PX = CNT_W'(BORDER);

  logic [CNT_W-1:0]  gx, gy;
  logic              blank, in_grid, border;
  logic [LOG_N-1:0]  row, col;
  pix_flags_t        flags_in, flags_s1;

  logic              rd_pend_q;
  logic [DATA_W-1:0] data_q;
  logic              vb_prev_q;
  logic              vblank_rise;
  logic              swap_ack_q;
  logic              buf_sel_q;
  logic [11:0]       rgb_q, rgb_d;
  logic [3:0]        shade;
  logic              unused_data_q;

  // Modular subtraction: coordinates left/above the origin wrap to large values and fail the range test.
  assign gx      = h_count - ORG_X;
  assign gy      = v_count - ORG_Y;
  assign blank   = hblank | vblank;
  assign in_grid = (gx < GRID_PX) && (gy < GRID_PX) && !blank;
  assign border  = ((gx & CELL_MASK) < BORDER_PX) || ((gy & CELL_MASK) < BORDER_PX);
  assign row     = gy[LOG_CELL +: LOG_N];
  assign col     = gx[LOG_CELL +: LOG_N];

  assign flags_in = '{valid: 1'b1, blank: blank, in_grid: in_grid, border: border};

  // Read issued combinationally on the strobe so data is captured before the next pix_en.
  assign mem_rd_en   = pix_en & in_grid & ~reset;
  assign mem_rd_addr = mem_rd_en ? ADDR_W'({buf_sel_q, row, col}) : '0;

  vga_sync_delay #(
    .DEPTH(2)
  ) u_sync_delay (
    .clk     (clk),
    .rst     (reset),
    .en      (pix_en),
    .hsync_i (hsync_in),
    .vsync_i (vsync_in),
    .flags_i (flags_in),
    .flags_o (flags_s1),
    .hsync_o (vga_hsync),
    .vsync_o (vga_vsync)
  );

  assign vblank_rise = pix_en & vblank & ~vb_prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend_q  <= 1'b0;
      data_q     <= '0;
      vb_prev_q  <= 1'b0;
      swap_ack_q <= 1'b0;
      buf_sel_q  <= 1'b0;
    end else begin
      rd_pend_q  <= mem_rd_en;
      if (rd_pend_q) data_q <= mem_rd_data;
      if (pix_en) vb_prev_q <= vblank;
      swap_ack_q <= vblank_rise & swap_req;
      if (vblank_rise && swap_req) buf_sel_q <= ~buf_sel_q;
    end
  end

  assign shade         = data_q[DATA_W-1 -: 4];
  assign unused_data_q = ^data_q;

  always_comb begin
    rgb_d = COL_BG;
    if (!flags_s1.valid || flags_s1.blank) begin
      rgb_d = COL_BLANK;
    end else if (flags_s1.in_grid) begin
      rgb_d = flags_s1.border ? COL_BORDER : {shade, shade, shade};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q <= '0;
    end else if (pix_en) begin
      rgb_q <= rgb_d;
    end
  end

  assign vga_r    = rgb_q[11:8];
  assign vga_g    = rgb_q[7:4];
  assign vga_b    = rgb_q[3:0];
  assign swap_ack = swap_ack_q;
  assign buf_sel  = buf_sel_q;

endmodule
